// File: rtl/wb_mem_tester_pkg.sv
// Shared types and helpers for the Wishbone memory tester.
// Latency: none (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, LFSR mask, error counter width, LFSR step.
package wb_mem_tester_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR_REQ = 3'd1,
      ST_WR_GAP = 3'd2,
      ST_RD_REQ = 3'd3,
      ST_RD_GAP = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
   localparam int          ERR_CNT_W = 16;

   // Galois LFSR step: shift right, fold the mask in when the bit shifted out is 1.
   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      return x[0] ? ((x >> 1) ^ LFSR_MASK) : (x >> 1);
   endfunction

endpackage

// File: rtl/wb_mem_tester_if.sv
// Wishbone B3 classic bus bundle between the tester (master) and a target (slave).
// Latency: none (wires only).
// Backpressure: the target stretches a cycle by withholding wb_ack_i / wb_err_i.
// Signals: cyc/stb/we/adr/dat_o/sel from master; ack/err/dat_i from slave.
interface wb_mem_tester_if;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic [31:0] wb_dat_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
      input  wb_ack_i, wb_err_i, wb_dat_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
      output wb_ack_i, wb_err_i, wb_dat_i
   );
endinterface

// File: rtl/wb_mem_tester_lfsr.sv
// Pattern generator register: loads a seed or advances one Galois LFSR step.
// Latency: q reflects load/adv one clock after they are sampled.
// Backpressure: holds its value whenever neither load nor adv is asserted.
// Ports: clk_i, rst_ni, load (priority over adv), adv, seed[31:0] -> q[31:0].
module wb_mem_tester_lfsr
   import wb_mem_tester_pkg::*;
#(
   parameter logic [31:0] RST_VAL = 32'hACE1_2345
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load,
   input  logic        adv,
   input  logic [31:0] seed,
   output logic [31:0] q
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   q <= RST_VAL;
      else if (load) q <= seed;
      else if (adv)  q <= lfsr_next(q);
   end

endmodule

// File: rtl/wb_mem_tester.sv
// Wishbone self-test initiator: writes an LFSR pattern over a word range, reads it back, compares.
// Latency: bus request one cycle after start; 2 cycles per zero-wait access plus a one-cycle gap.
// Backpressure: each request is held stable until the target returns ack or err.
// Ports: clk_i, rst_ni, start_i; status busy/done/pass/timeout, err_count, first_err_*; wb (master).
// Optional: WB_MEM_TESTER_TIMEOUT_EN adds an ack watchdog of TIMEOUT_CYCLES cycles per request.
module wb_mem_tester
   import wb_mem_tester_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
   parameter int          WORDS          = 1024,
   parameter logic [31:0] LFSR_SEED      = 32'hACE1_2345,
   parameter int          TIMEOUT_CYCLES = 1023
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic                 timeout_o,
   output logic [ERR_CNT_W-1:0] err_count_o,
   output logic [31:0]          first_err_adr_o,
   output logic [31:0]          first_err_exp_o,
   output logic [31:0]          first_err_got_o,
   wb_mem_tester_if.master      wb
);

   if (WORDS < 1 || WORDS > 65535) begin : g_bad_words
      $error("wb_mem_tester: WORDS must be in 1..65535");
   end
   if (ADDR_BASE[1:0] != 2'b00) begin : g_bad_base
      $error("wb_mem_tester: ADDR_BASE must be 4-byte aligned");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
      $error("wb_mem_tester: TIMEOUT_CYCLES must be in 1..65535");
   end

   localparam logic [15:0] LAST_IDX = 16'(WORDS - 1);

   state_t                state, state_n;
   logic [15:0]           idx, idx_n;
   logic [31:0]           adr_q, adr_n;
   logic [ERR_CNT_W-1:0]  err_cnt, cnt_n;
   logic [31:0]           fadr_n, fexp_n, fgot_n;
   logic                  timeout_q, timeout_n;
   logic                  cyc_q, we_q, busy_q, done_q, pass_q;
   logic [3:0]            sel_q;
   logic                  lfsr_load, lfsr_adv;
   logic [31:0]           lfsr_q;
   logic                  resp, last, mism, req_n, pass_n;
   logic [31:0]           got_v;
`ifdef WB_MEM_TESTER_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]           tmo_cnt, tmo_n;
`endif

   wb_mem_tester_lfsr #(.RST_VAL(LFSR_SEED)) u_lfsr (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .load  (lfsr_load),
      .adv   (lfsr_adv),
      .seed  (LFSR_SEED),
      .q     (lfsr_q)
   );

   always_comb begin
      state_n   = state;
      idx_n     = idx;
      adr_n     = adr_q;
      cnt_n     = err_cnt;
      fadr_n    = first_err_adr_o;
      fexp_n    = first_err_exp_o;
      fgot_n    = first_err_got_o;
      timeout_n = timeout_q;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      mism      = 1'b0;
      got_v     = '0;
      // err wins over ack when both arrive together; either one ends the access.
      resp      = wb.wb_ack_i | wb.wb_err_i;
      last      = (idx == LAST_IDX);

      case (state)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_n   = ST_WR_REQ;
               idx_n     = '0;
               adr_n     = ADDR_BASE;
               cnt_n     = '0;
               fadr_n    = '0;
               fexp_n    = '0;
               fgot_n    = '0;
               timeout_n = 1'b0;
               lfsr_load = 1'b1;
            end
         end
         ST_WR_REQ: begin
            if (resp) begin
               mism     = wb.wb_err_i;
               lfsr_adv = 1'b1;
               if (last) begin
                  // Rewind pattern and address so the read pass regenerates the same sequence.
                  idx_n     = '0;
                  adr_n     = ADDR_BASE;
                  lfsr_load = 1'b1;
                  state_n   = ST_RD_GAP;
               end else begin
                  idx_n   = idx + 16'd1;
                  adr_n   = adr_q + 32'd4;
                  state_n = ST_WR_GAP;
               end
            end
         end
         ST_WR_GAP: state_n = ST_WR_REQ;
         ST_RD_GAP: state_n = ST_RD_REQ;
         ST_RD_REQ: begin
            if (resp) begin
               mism     = wb.wb_err_i | (wb.wb_dat_i != lfsr_q);
               got_v    = wb.wb_dat_i;
               lfsr_adv = 1'b1;
               if (last) begin
                  state_n = ST_DONE;
               end else begin
                  idx_n   = idx + 16'd1;
                  adr_n   = adr_q + 32'd4;
                  state_n = ST_RD_GAP;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (mism) begin
         if (err_cnt == '0) begin
            fadr_n = adr_q;
            fexp_n = lfsr_q;
            fgot_n = got_v;
         end
         if (err_cnt != '1) cnt_n = err_cnt + 1'b1;
      end

`ifdef WB_MEM_TESTER_TIMEOUT_EN
      // Counter is zero outside REQ, so every REQ entry starts counting from 0.
      tmo_n = '0;
      if ((state == ST_WR_REQ || state == ST_RD_REQ) && !resp) begin
         tmo_n = tmo_cnt + 16'd1;
         if (tmo_cnt == TMO_LAST) begin
            state_n   = ST_DONE;
            timeout_n = 1'b1;
         end
      end
`endif

      req_n  = (state_n == ST_WR_REQ) || (state_n == ST_RD_REQ);
      pass_n = (state_n == ST_DONE) && (cnt_n == '0) && !timeout_n;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state           <= ST_IDLE;
         idx             <= '0;
         adr_q           <= '0;
         err_cnt         <= '0;
         first_err_adr_o <= '0;
         first_err_exp_o <= '0;
         first_err_got_o <= '0;
         timeout_q       <= 1'b0;
         cyc_q           <= 1'b0;
         we_q            <= 1'b0;
         sel_q           <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         pass_q          <= 1'b0;
      end else begin
         state           <= state_n;
         idx             <= idx_n;
         adr_q           <= adr_n;
         err_cnt         <= cnt_n;
         first_err_adr_o <= fadr_n;
         first_err_exp_o <= fexp_n;
         first_err_got_o <= fgot_n;
         timeout_q       <= timeout_n;
         cyc_q           <= req_n;
         we_q            <= (state_n == ST_WR_REQ);
         sel_q           <= req_n ? 4'hF : 4'h0;
         busy_q          <= (state_n != ST_IDLE) && (state_n != ST_DONE);
         done_q          <= (state_n == ST_DONE);
         pass_q          <= pass_n;
      end
   end

`ifdef WB_MEM_TESTER_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) tmo_cnt <= '0;
      else         tmo_cnt <= tmo_n;
   end
`endif

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign timeout_o   = timeout_q;
   assign err_count_o = err_cnt;

   assign wb.wb_cyc_o = cyc_q;
   assign wb.wb_stb_o = cyc_q;
   assign wb.wb_we_o  = we_q;
   assign wb.wb_sel_o = sel_q;
   assign wb.wb_adr_o = adr_q;
   // The LFSR resets to the seed, so gate it to keep write data at 0 outside writes.
   assign wb.wb_dat_o = we_q ? lfsr_q : 32'h0;

endmodule
